// File: rtl/braun_mac_pkg.sv
// Shared types, parameter rules and operand helpers for the sequential Braun MAC.
package braun_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BPC   = 2;
    localparam int N_ITER    = DEF_WIDTH / DEF_BPC;

    function automatic int n_iter(input int width, input int bpc);
        return width / bpc;
    endfunction

    function automatic bit params_legal(input int width, input int bpc, input int acc_width);
        return (width % 2 == 0) && (width >= 4) && (width <= 32) &&
               ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (width % bpc == 0) &&
               (acc_width >= 2 * width);
    endfunction

    // Magnitude of a width-bit operand; -2^(width-1) maps to 2^(width-1), which still fits.
    function automatic logic [31:0] abs_mag(input logic [31:0] value, input int width,
                                            input logic is_signed);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        if (is_signed && value[width-1]) begin
            return (~value + 32'd1) & mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/braun_row_slice.sv
// BITS_PER_CYCLE rows of a Braun array: adds the selected partial-product rows
// of the multiplicand into the running 2*WIDTH partial sum.
module braun_row_slice #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 2,
    parameter int OFF_W          = 4
) (
    input  logic [WIDTH-1:0]          a_mag,
    input  logic [BITS_PER_CYCLE-1:0] b_slice,
    input  logic [OFF_W-1:0]          offset,
    input  logic [2*WIDTH-1:0]        sum_in,
    output logic [2*WIDTH-1:0]        sum_out
);
    localparam int SUM_W = 2 * WIDTH;

    logic [BITS_PER_CYCLE:0][SUM_W-1:0] row_sum;

    assign row_sum[0] = sum_in;
    assign sum_out    = row_sum[BITS_PER_CYCLE];

    for (genvar r = 0; r < BITS_PER_CYCLE; r++) begin : g_row
        logic [SUM_W-1:0] pp;
        logic [SUM_W-2:0] carry;

        assign pp = {{WIDTH{1'b0}}, a_mag & {WIDTH{b_slice[r]}}} << (offset + OFF_W'(r));

        for (genvar i = 0; i < SUM_W; i++) begin : g_cell
            if (i == 0) begin : g_ha
                ha u_ha (
                    .a (row_sum[r][0]),
                    .b (pp[0]),
                    .s (row_sum[r+1][0]),
                    .c (carry[0])
                );
            end else if (i < SUM_W - 1) begin : g_fa
                fa u_fa (
                    .a  (row_sum[r][i]),
                    .b  (pp[i]),
                    .ci (carry[i-1]),
                    .s  (row_sum[r+1][i]),
                    .co (carry[i])
                );
            end else begin : g_msb
                // The exact product never exceeds 2*WIDTH bits, so the top carry is dropped.
                assign row_sum[r+1][i] = row_sum[r][i] ^ pp[i] ^ carry[i-1];
            end
        end
    end

endmodule

// File: rtl/fa.sv
// Full-adder cell of the Braun array.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/ha.sv
// Half-adder cell of the Braun array.
module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/braun_mac_seq.sv
// Multi-cycle signed/unsigned multiply-accumulate built around a Braun row slice,
// with valid/ready handshakes on the operand and result sides.
module braun_mac_seq
    import braun_mac_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 2,
    parameter int ACC_WIDTH      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic                 in_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);
    localparam int SUM_W = 2 * WIDTH;
    localparam int N     = n_iter(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int OFF_W = $clog2(SUM_W);

    if (!params_legal(WIDTH, BITS_PER_CYCLE, ACC_WIDTH)) begin : g_param_check
        $error("braun_mac_seq: illegal WIDTH/BITS_PER_CYCLE/ACC_WIDTH combination");
    end

    state_t               state_q,    state_d;
    logic [CNT_W-1:0]     iter_q,     iter_d;
    logic [WIDTH-1:0]     a_q,        a_d;
    logic [WIDTH-1:0]     b_q,        b_d;
    logic                 signed_q,   signed_d;
    logic                 acc_mode_q, acc_mode_d;
    logic                 neg_q,      neg_d;
    logic [SUM_W-1:0]     sum_q,      sum_d;
    logic [SUM_W-1:0]     prod_q,     prod_d;
    logic [ACC_WIDTH-1:0] acc_q,      acc_d;
    logic                 ovf_q,      ovf_d;

    logic [OFF_W-1:0]     offset;
    logic [SUM_W-1:0]     slice_sum;
    logic [SUM_W-1:0]     prod_fix;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 ovf_fix;

    // The multiplier register shifts right each iteration, so its low bits are always the live slice.
    assign offset = OFF_W'(iter_q) * OFF_W'(BITS_PER_CYCLE);

    braun_row_slice #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE),
        .OFF_W          (OFF_W)
    ) u_slice (
        .a_mag   (a_q),
        .b_slice (b_q[BITS_PER_CYCLE-1:0]),
        .offset  (offset),
        .sum_in  (sum_q),
        .sum_out (slice_sum)
    );

    always_comb begin
        prod_fix = neg_q ? (SUM_W'(0) - sum_q) : sum_q;
        ext      = signed_q ? ACC_WIDTH'($signed(prod_fix)) : ACC_WIDTH'(prod_fix);
        acc_sum  = {1'b0, acc_q} + {1'b0, ext};
        if (signed_q) begin
            ovf_fix = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                      (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            ovf_fix = acc_sum[ACC_WIDTH];
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_prod  = prod_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a latch behind.
        state_d    = state_q;
        iter_d     = iter_q;
        a_d        = a_q;
        b_d        = b_q;
        signed_d   = signed_q;
        acc_mode_d = acc_mode_q;
        neg_d      = neg_q;
        sum_d      = sum_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d        = WIDTH'(abs_mag(32'(in_a), WIDTH, in_signed));
                    b_d        = WIDTH'(abs_mag(32'(in_b), WIDTH, in_signed));
                    signed_d   = in_signed;
                    acc_mode_d = in_acc;
                    neg_d      = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    sum_d      = '0;
                    iter_d     = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                sum_d  = slice_sum;
                b_d    = b_q >> BITS_PER_CYCLE;
                iter_d = iter_q + CNT_W'(1);
                if (iter_q == CNT_W'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                prod_d  = prod_fix;
                acc_d   = acc_mode_q ? acc_sum[ACC_WIDTH-1:0] : ext;
                ovf_d   = acc_mode_q & ovf_fix;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            signed_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            neg_q      <= 1'b0;
            sum_q      <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every register see the pre-edge values of the others.
            state_q    <= state_d;
            iter_q     <= iter_d;
            a_q        <= a_d;
            b_q        <= b_d;
            signed_q   <= signed_d;
            acc_mode_q <= acc_mode_d;
            neg_q      <= neg_d;
            sum_q      <= sum_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_braun_mac_seq.sv
// Self-checking bench: a 24-bit and a 16-bit accumulator build share one stimulus stream.
module tb_braun_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_signed, in_acc, out_ready;
    logic [7:0]  in_a, in_b;

    logic        in_ready24, out_valid24, ovf24;
    logic [15:0] prod24;
    logic [23:0] acc24;
    logic        in_ready16, out_valid16, ovf16;
    logic [15:0] prod16;
    logic [15:0] acc16;

    int n_tests = 0;
    int n_fail  = 0;

    longint m_acc24 = 0;
    longint m_acc16 = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        bit          s;
        bit          accm;
        logic [15:0] prod;
        logic [23:0] acc24;
        bit          ovf24;
        logic [15:0] acc16;
        bit          ovf16;
    } vec_t;

    vec_t vecs[12];

    braun_mac_seq #(.WIDTH(8), .BITS_PER_CYCLE(2), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready24),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
        .out_valid(out_valid24), .out_ready(out_ready), .out_prod(prod24),
        .out_acc(acc24), .out_ovf(ovf24)
    );

    braun_mac_seq #(.WIDTH(8), .BITS_PER_CYCLE(2), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_acc(in_acc),
        .out_valid(out_valid16), .out_ready(out_ready), .out_prod(prod16),
        .out_acc(acc16), .out_ovf(ovf16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact integer product, accumulator wrapped modulo 2^aw.
    function automatic void model_op(input logic [7:0] a, input logic [7:0] b, input bit s,
                                     input bit accm, input int aw, inout longint acc,
                                     output logic [15:0] prod, output bit ovf);
        longint pa, pb, p, md, r, sa;
        pa   = s ? longint'($signed(a)) : longint'(a);
        pb   = s ? longint'($signed(b)) : longint'(b);
        p    = pa * pb;
        prod = p[15:0];
        md   = longint'(1) << aw;
        if (!accm) begin
            acc = ((p % md) + md) % md;
            ovf = 1'b0;
        end else if (s) begin
            sa  = (acc >= md / 2) ? acc - md : acc;
            r   = sa + p;
            ovf = (r >= md / 2) || (r < -(md / 2));
            acc = ((r % md) + md) % md;
        end else begin
            r   = acc + p;
            ovf = (r >= md);
            acc = r % md;
        end
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit accm,
                          input string tag, input bit early_ready,
                          output logic [15:0] prod_o, output logic [23:0] acc24_o,
                          output logic ovf24_o, output logic [15:0] acc16_o,
                          output logic ovf16_o);
        int waited = 0;
        int lat    = 0;
        bit ready_seen = 0;
        while (!(in_ready24 && in_ready16) && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, " ready before accept"}, 64'({in_ready24, in_ready16}), 64'h3);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_acc    = accm;
        in_valid  = 1'b1;
        out_ready = early_ready;
        tick();
        while (!out_valid24 && lat < 20) begin
            if (in_ready24 || in_ready16) ready_seen = 1;
            in_valid  = 1'(early_ready & $urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_signed = 1'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd5);
        check({tag, " in_ready low while busy"}, 64'(ready_seen), 64'd0);
        check({tag, " out_valid16"}, 64'(out_valid16), 64'd1);
        prod_o  = prod24;
        acc24_o = acc24;
        ovf24_o = ovf24;
        acc16_o = acc16;
        ovf16_o = ovf16;
        check({tag, " prod16 equals prod24"}, 64'(prod16), 64'(prod24));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'({out_valid24, out_valid16}), 64'd0);
    endtask

    initial begin
        logic [15:0] p, ep;
        logic [23:0] a24;
        logic [15:0] a16;
        logic        o24, o16;
        bit          eo;

        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 24'h00FE01, 1'b0, 16'hFE01, 1'b0};
        vecs[1]  = '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 24'h004000, 1'b0, 16'h4000, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 1'b1, 1'b0, 16'hFF80, 24'hFFFF80, 1'b0, 16'hFF80, 1'b0};
        vecs[3]  = '{8'hC8, 8'hC8, 1'b0, 1'b0, 16'h9C40, 24'h009C40, 1'b0, 16'h9C40, 1'b0};
        vecs[4]  = '{8'h64, 8'h03, 1'b0, 1'b1, 16'h012C, 24'h009D6C, 1'b0, 16'h9D6C, 1'b0};
        vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 24'h00FE01, 1'b0, 16'hFE01, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01, 24'h01FC02, 1'b0, 16'hFC02, 1'b1};
        vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01, 24'h023B03, 1'b0, 16'h3B03, 1'b0};
        vecs[8]  = '{8'h80, 8'h7F, 1'b1, 1'b1, 16'hC080, 24'h01FB83, 1'b0, 16'hFB83, 1'b0};
        vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01, 24'h023A84, 1'b0, 16'h3A84, 1'b0};
        vecs[10] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01, 24'h027985, 1'b0, 16'h7985, 1'b0};
        vecs[11] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3F01, 24'h02B886, 1'b0, 16'hB886, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        in_acc    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", 64'({in_ready24, in_ready16}), 64'd0);
        check("reset out_valid", 64'({out_valid24, out_valid16}), 64'd0);
        check("reset outputs 24", 64'({prod24, acc24, ovf24}), 64'd0);
        check("reset outputs 16", 64'({prod16, acc16, ovf16}), 64'd0);
        rst = 1'b0;
        tick();
        check("in_ready after release", 64'({in_ready24, in_ready16}), 64'h3);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].accm, $sformatf("vec%0d", i), 1'b0,
                   p, a24, o24, a16, o16);
            check($sformatf("vec%0d prod", i),  64'(p),   64'(vecs[i].prod));
            check($sformatf("vec%0d acc24", i), 64'(a24), 64'(vecs[i].acc24));
            check($sformatf("vec%0d ovf24", i), 64'(o24), 64'(vecs[i].ovf24));
            check($sformatf("vec%0d acc16", i), 64'(a16), 64'(vecs[i].acc16));
            check($sformatf("vec%0d ovf16", i), 64'(o16), 64'(vecs[i].ovf16));
            model_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].accm, 24, m_acc24, ep, eo);
            model_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].accm, 16, m_acc16, ep, eo);
        end

        // Result held in DONE while the consumer stalls; extra requests are dropped.
        begin
            int wait_n = 0;
            model_op(8'h12, 8'h34, 1'b0, 1'b0, 24, m_acc24, ep, eo);
            model_op(8'h12, 8'h34, 1'b0, 1'b0, 16, m_acc16, ep, eo);
            in_a = 8'h12; in_b = 8'h34; in_signed = 1'b0; in_acc = 1'b0; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            while (!out_valid24 && wait_n < 20) begin
                tick();
                wait_n++;
            end
            check("stall reached DONE", 64'(out_valid24), 64'd1);
            for (int c = 0; c < 10; c++) begin
                in_valid  = 1'b1;
                in_a      = 8'($urandom);
                in_b      = 8'($urandom);
                in_acc    = 1'b1;
                tick();
                check($sformatf("stall hold c%0d", c),
                      64'({out_valid24, in_ready24, prod24, acc24}),
                      64'({1'b1, 1'b0, 16'h03A8, 24'h0003A8}));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("stall release", 64'({out_valid24, in_ready24}), 64'b01);
            for (int c = 0; c < 8; c++) tick();
            check("no queued request", 64'({out_valid24, in_ready24, acc24, acc16}),
                  64'({1'b0, 1'b1, 24'h0003A8, 16'h03A8}));
        end

        // Reset in the middle of BUSY iteration 2 clears everything, accumulator included.
        in_a = 8'hAB; in_b = 8'hCD; in_signed = 1'b0; in_acc = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid-busy reset 24", 64'({in_ready24, out_valid24, prod24, acc24, ovf24}), 64'd0);
        check("mid-busy reset 16", 64'({in_ready16, out_valid16, prod16, acc16, ovf16}), 64'd0);
        tick();
        rst     = 1'b0;
        m_acc24 = 0;
        m_acc16 = 0;
        tick();
        run_op(8'd3, 8'd5, 1'b0, 1'b1, "post-reset", 1'b0, p, a24, o24, a16, o16);
        check("post-reset prod", 64'(p), 64'h000F);
        check("post-reset acc", 64'({a24, a16, o24, o16}), 64'({24'h00000F, 16'h000F, 2'b00}));
        model_op(8'd3, 8'd5, 1'b0, 1'b1, 24, m_acc24, ep, eo);
        model_op(8'd3, 8'd5, 1'b0, 1'b1, 16, m_acc16, ep, eo);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            bit rs, racc;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 1'($urandom);
            racc = ($urandom_range(0, 3) != 0);
            run_op(ra, rb, rs, racc, $sformatf("rand%0d", i), 1'($urandom), p, a24, o24, a16, o16);
            model_op(ra, rb, rs, racc, 24, m_acc24, ep, eo);
            check($sformatf("rand%0d prod", i), 64'(p), 64'(ep));
            check($sformatf("rand%0d acc24", i), 64'({a24, o24}), 64'({m_acc24[23:0], eo}));
            model_op(ra, rb, rs, racc, 16, m_acc16, ep, eo);
            check($sformatf("rand%0d acc16", i), 64'({a16, o16}), 64'({m_acc16[15:0], eo}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
